// File: rtl/generador_transacciones.sv
// I2C controller-side transaction generator: drives SCL, issues START/STOP,
// the 7-bit address, the R/W bit and one 16-bit word, and collects ACKs and
// read data returned on SDA_IN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus released (SCL=1, SDA=1), waiting for START_STB
// START     | SDA held low with SCL high for DIV/2 cycles
// ADDR      | 8 slots: A6..A0 then R/W
// ADDR_ACK  | 1 slot, SDA released, target ACK sampled
// WR_BYTE   | 8 slots of write data, MSB first
// WR_ACK    | 1 slot, SDA released, target ACK sampled
// RD_BYTE   | 8 slots, SDA released, read data shifted in MSB first
// RD_ACK    | 1 slot, generator drives ACK (first byte) or NACK (second)
// STOP      | 1 slot with SDA low; SDA rises with SCL high on exit to IDLE
module generador_transacciones #(
    parameter int DIV = 4
) (
    input  logic        clk_generador,
    input  logic        rst_generador,
    input  logic        START_STB_generador,
    input  logic        RNW_generador,
    input  logic [6:0]  I2C_ADDR_generador,
    input  logic [15:0] WR_DATA_generador,
    input  logic        SDA_IN,
    output logic        SCL,
    output logic        SDA_OUT,
    output logic        SDA_OE,
    output logic [15:0] RD_DATA_generador,
    output logic        BUSY_generador,
    output logic        NACK_ERR_generador
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_HALF_M1 = PW'(DIV/2 - 1);
    localparam logic [PW-1:0] PH_HALF    = PW'(DIV/2);
    localparam logic [PW-1:0] PH_LAST    = PW'(DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_phase;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic          r_rnw;
    logic [15:0]   r_wr_data;
    logic          r_second;
    logic          r_ack;
    logic [15:0]   r_rd_shift;

    // Sequencer: phase counter within a bit slot, slot-to-slot transitions and
    // all registered bus outputs. Each slot's SDA value is set on the same edge
    // that drops SCL, so SDA only moves while SCL is low.
    always_ff @(posedge clk_generador or posedge rst_generador) begin
        if (rst_generador) begin
            r_state            <= S_IDLE;
            r_phase            <= '0;
            r_bit              <= '0;
            r_tx               <= '0;
            r_rnw              <= 1'b0;
            r_wr_data          <= '0;
            r_second           <= 1'b0;
            r_ack              <= 1'b0;
            r_rd_shift         <= '0;
            SCL                <= 1'b1;
            SDA_OUT            <= 1'b1;
            SDA_OE             <= 1'b1;
            RD_DATA_generador  <= '0;
            BUSY_generador     <= 1'b0;
            NACK_ERR_generador <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START_STB_generador) begin
                        r_tx               <= {I2C_ADDR_generador, RNW_generador};
                        r_rnw              <= RNW_generador;
                        r_wr_data          <= WR_DATA_generador;
                        r_phase            <= '0;
                        BUSY_generador     <= 1'b1;
                        NACK_ERR_generador <= 1'b0;
                        SDA_OUT            <= 1'b0;
                        r_state            <= S_START;
                    end
                end

                S_START: begin
                    if (r_phase == PH_HALF_M1) begin
                        r_phase <= '0;
                        r_bit   <= '0;
                        SCL     <= 1'b0;
                        SDA_OUT <= r_tx[7];
                        SDA_OE  <= 1'b1;
                        r_state <= S_ADDR;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                default: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end

                    if (r_phase == PH_HALF_M1) begin
                        SCL <= 1'b1;
                    end

                    // SDA_IN is only looked at in slots where the target owns SDA
                    if (r_phase == PH_HALF) begin
                        case (r_state)
                            S_ADDR_ACK, S_WR_ACK: r_ack <= SDA_IN;
                            S_RD_BYTE: begin
                                r_rd_shift <= {r_rd_shift[14:0], SDA_IN};
                                if (r_second && (r_bit == 3'd7)) begin
                                    RD_DATA_generador <= {r_rd_shift[14:0], SDA_IN};
                                end
                            end
                            default: ;
                        endcase
                    end

                    if (r_phase == PH_LAST) begin
                        SCL <= 1'b0;
                        case (r_state)
                            S_ADDR: begin
                                if (r_bit == 3'd7) begin
                                    SDA_OE  <= 1'b0;
                                    SDA_OUT <= 1'b1;
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_bit   <= r_bit + 3'd1;
                                    r_tx    <= {r_tx[6:0], 1'b0};
                                    SDA_OUT <= r_tx[6];
                                end
                            end
                            S_ADDR_ACK: begin
                                r_bit    <= '0;
                                r_second <= 1'b0;
                                if (r_ack) begin
                                    NACK_ERR_generador <= 1'b1;
                                    SDA_OE  <= 1'b1;
                                    SDA_OUT <= 1'b0;
                                    r_state <= S_STOP;
                                end else if (r_rnw) begin
                                    SDA_OE  <= 1'b0;
                                    r_state <= S_RD_BYTE;
                                end else begin
                                    r_tx    <= r_wr_data[15:8];
                                    SDA_OE  <= 1'b1;
                                    SDA_OUT <= r_wr_data[15];
                                    r_state <= S_WR_BYTE;
                                end
                            end
                            S_WR_BYTE: begin
                                if (r_bit == 3'd7) begin
                                    SDA_OE  <= 1'b0;
                                    SDA_OUT <= 1'b1;
                                    r_state <= S_WR_ACK;
                                end else begin
                                    r_bit   <= r_bit + 3'd1;
                                    r_tx    <= {r_tx[6:0], 1'b0};
                                    SDA_OUT <= r_tx[6];
                                end
                            end
                            S_WR_ACK: begin
                                if (r_ack) begin
                                    NACK_ERR_generador <= 1'b1;
                                end
                                SDA_OE <= 1'b1;
                                if (r_ack || r_second) begin
                                    SDA_OUT <= 1'b0;
                                    r_state <= S_STOP;
                                end else begin
                                    r_second <= 1'b1;
                                    r_bit    <= '0;
                                    r_tx     <= r_wr_data[7:0];
                                    SDA_OUT  <= r_wr_data[7];
                                    r_state  <= S_WR_BYTE;
                                end
                            end
                            S_RD_BYTE: begin
                                if (r_bit == 3'd7) begin
                                    SDA_OE  <= 1'b1;
                                    SDA_OUT <= r_second;
                                    r_state <= S_RD_ACK;
                                end else begin
                                    r_bit <= r_bit + 3'd1;
                                end
                            end
                            S_RD_ACK: begin
                                if (r_second) begin
                                    SDA_OE  <= 1'b1;
                                    SDA_OUT <= 1'b0;
                                    r_state <= S_STOP;
                                end else begin
                                    r_second <= 1'b1;
                                    r_bit    <= '0;
                                    SDA_OE   <= 1'b0;
                                    SDA_OUT  <= 1'b1;
                                    r_state  <= S_RD_BYTE;
                                end
                            end
                            S_STOP: begin
                                // SCL is already high here; releasing SDA now forms STOP
                                SCL            <= 1'b1;
                                SDA_OUT        <= 1'b1;
                                SDA_OE         <= 1'b1;
                                BUSY_generador <= 1'b0;
                                r_state        <= S_IDLE;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_transacciones.sv
// Bench for generador_transacciones: a behavioural I2C target answers on
// SDA_IN, a slot-level reference model predicts each transaction, and a
// monitor compares the observed transaction when BUSY falls.
module tb_generador_transacciones;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic        sda_in;
    logic        scl, sda_out, sda_oe, busy, nack_err;
    logic [15:0] rd_data;

    always #5 clk = ~clk;

    generador_transacciones #(.DIV(DIV)) dut (
        .clk_generador       (clk),
        .rst_generador       (rst),
        .START_STB_generador (stb),
        .RNW_generador       (rnw),
        .I2C_ADDR_generador  (addr),
        .WR_DATA_generador   (wdata),
        .SDA_IN              (sda_in),
        .SCL                 (scl),
        .SDA_OUT             (sda_out),
        .SDA_OE              (sda_oe),
        .RD_DATA_generador   (rd_data),
        .BUSY_generador      (busy),
        .NACK_ERR_generador  (nack_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // expected view of one transaction, slot by slot
    typedef struct {
        int          n;
        logic [31:0] oe;
        logic [31:0] out;
        int          dur;
        logic        nack;
        logic [15:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rd_model = 16'h0000;
    bit          abort_pending = 1'b0;

    // target behaviour for the current transaction
    logic        t_rnw = 1'b0;
    logic        t_na = 1'b0, t_n1 = 1'b0, t_n2 = 1'b0;
    logic [15:0] t_rd = 16'h0000;

    function automatic exp_t model(input logic [6:0] a, input logic r, input logic [15:0] wd,
                                   input logic na, input logic n1, input logic n2,
                                   input logic [15:0] rdv, input logic [15:0] prev);
        exp_t       e;
        logic [7:0] ab;
        logic [7:0] db;
        bit         done;
        e.n   = 0;
        e.oe  = '0;
        e.out = '0;
        done  = 1'b0;
        ab    = {a, r};
        for (int i = 7; i >= 0; i--) begin
            e.oe[e.n] = 1'b1; e.out[e.n] = ab[i]; e.n = e.n + 1;
        end
        e.n = e.n + 1;                       // address ACK slot, target drives
        if (!na) begin
            if (!r) begin
                for (int b = 0; b < 2; b++) begin
                    if (!done) begin
                        db = (b == 0) ? wd[15:8] : wd[7:0];
                        for (int i = 7; i >= 0; i--) begin
                            e.oe[e.n] = 1'b1; e.out[e.n] = db[i]; e.n = e.n + 1;
                        end
                        e.n = e.n + 1;       // data ACK slot, target drives
                        if (b == 0 && n1) done = 1'b1;
                    end
                end
            end else begin
                for (int b = 0; b < 2; b++) begin
                    e.n = e.n + 8;           // read bits, target drives
                    e.oe[e.n] = 1'b1; e.out[e.n] = (b == 1); e.n = e.n + 1;
                end
            end
        end
        e.oe[e.n] = 1'b1; e.out[e.n] = 1'b0; e.n = e.n + 1;   // STOP slot
        e.dur  = DIV/2 + e.n * DIV;
        e.nack = na | (!r & (n1 | n2));
        e.rd   = (r && !na) ? rdv : prev;
        return e;
    endfunction

    // behavioural target: new bit presented after each SCL fall
    logic tp_scl = 1'b1, tp_busy = 1'b0;
    int   tslot = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && tp_busy !== 1'b1) tslot = 0;
            if (busy === 1'b1 && scl === 1'b0 && tp_scl === 1'b1) begin
                if (tslot == 8)                               sda_in = t_na;
                else if (t_rnw && tslot >= 9 && tslot <= 16)  sda_in = t_rd[15 - (tslot - 9)];
                else if (t_rnw && tslot >= 18 && tslot <= 25) sda_in = t_rd[7 - (tslot - 18)];
                else if (!t_rnw && tslot == 17)               sda_in = t_n1;
                else if (!t_rnw && tslot == 26)               sda_in = t_n2;
                else                                          sda_in = 1'($urandom_range(0, 1));
                tslot++;
            end
            tp_scl  = scl;
            tp_busy = busy;
        end
    end

    // monitor: record SDA at every SCL rise, compare when BUSY falls
    logic        m_pscl = 1'b1, m_psda = 1'b1, m_pbusy = 1'b0;
    int          m_cyc = 0, m_tstart = 0, m_nslot = 0, m_viol = 0;
    logic [31:0] m_oe = '0, m_out = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            m_cyc++;
            if (busy === 1'b1 && m_pbusy !== 1'b1) begin
                m_tstart = m_cyc; m_nslot = 0; m_viol = 0; m_oe = '0; m_out = '0;
            end
            if (busy === 1'b1 && scl === 1'b1 && m_pscl === 1'b0 && m_nslot < 32) begin
                m_oe[m_nslot]  = sda_oe;
                m_out[m_nslot] = sda_out;
                m_nslot++;
            end
            if (busy === 1'b1 && m_pbusy === 1'b1 && scl === 1'b1 && m_pscl === 1'b1 && sda_out !== m_psda)
                m_viol++;
            if (busy === 1'b0 && m_pbusy === 1'b1) begin
                if (abort_pending) begin
                    abort_pending = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check("unexpected_transaction", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("slot_count", m_nslot, e.n);
                    check("sda_oe_pattern", m_oe, e.oe);
                    check("sda_out_bits", m_out & e.oe, e.out & e.oe);
                    check("busy_cycles", m_cyc - m_tstart, e.dur);
                    check("nack_err", {31'd0, nack_err}, {31'd0, e.nack});
                    check("rd_data", {16'd0, rd_data}, {16'd0, e.rd});
                    check("sda_change_scl_high", m_viol, 0);
                end
            end
            m_pscl  = scl;
            m_psda  = sda_out;
            m_pbusy = busy;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy === 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    // called on a negedge with BUSY low; strobes on that same cycle
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [15:0] wd,
                           input logic na, input logic n1, input logic n2,
                           input logic [15:0] rdv, input bit pulse);
        exp_t e;
        t_rnw = r; t_na = na; t_n1 = n1; t_n2 = n2; t_rd = rdv;
        e = model(a, r, wd, na, n1, n2, rdv, rd_model);
        rd_model = e.rd;
        exp_q.push_back(e);
        stb = 1'b1; addr = a; rnw = r; wdata = wd;
        @(posedge clk); #1;
        check("accept_busy_sda_scl", {29'd0, busy, sda_out, scl}, 32'b101);
        @(negedge clk);
        stb = 1'b0; addr = 7'($urandom); rnw = 1'($urandom); wdata = 16'($urandom);
        if (pulse) begin
            repeat (9) @(negedge clk);
            stb = 1'b1; addr = ~a; rnw = ~r;
            @(negedge clk);
            stb = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [6:0]  ra;
        logic [15:0] rw, rr;
        logic        rrnw, rna, rn1, rn2;
        rst = 1'b0; stb = 1'b0; rnw = 1'b0; addr = '0; wdata = '0; sda_in = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("reset_bus_outputs", {27'd0, scl, sda_out, sda_oe, busy, nack_err}, 32'b11100);
        check("reset_rd_data", {16'd0, rd_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(7'h3D, 1'b0, 16'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        run_txn(7'h3D, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0);
        run_txn(7'h3D, 1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        run_txn(7'h3D, 1'b0, 16'hC0DE, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        run_txn(7'h12, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        run_txn(7'h3D, 1'b0, 16'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_txn(7'h3D, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0);

        // reset about 50 cycles into a read
        t_rnw = 1'b1; t_na = 1'b0; t_rd = 16'hBEEF;
        abort_pending = 1'b1;
        stb = 1'b1; addr = 7'h3D; rnw = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (49) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midreset_bus_outputs", {27'd0, scl, sda_out, sda_oe, busy, nack_err}, 32'b11100);
        check("midreset_rd_data", {16'd0, rd_data}, 32'd0);
        rd_model = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        run_txn(7'h3D, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ra   = 7'($urandom);
            rrnw = 1'($urandom_range(0, 1));
            rw   = 16'($urandom);
            rr   = 16'($urandom);
            rna  = ($urandom_range(0, 7) == 0);
            rn1  = ($urandom_range(0, 3) == 0);
            rn2  = ($urandom_range(0, 3) == 0);
            run_txn(ra, rrnw, rw, rna, rn1, rn2, rr, (i % 4) == 1);
        end

        repeat (6) @(negedge clk);
        check("busy_stays_low", {31'd0, busy}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
